// File: rtl/ram_responder.sv
// Byte-wide memory target: 64 KiB RAM plus a memory-mapped I/O data port and status register.
// Define RAM_RESPONDER_IO_FIFO_EN to buffer I/O writes in a FIFO; otherwise the port is a one-cycle strobe.
module ram_responder #(
    parameter int unsigned FIFO_DEPTH = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [16:0] a_in,
    input  logic [7:0]  d_in,
    input  logic        wr,
    output logic [7:0]  d_out,
    output logic [7:0]  io_data,
    output logic        io_valid,
    input  logic        io_ready
);

    localparam int unsigned ADDR_W   = 17;
    localparam int unsigned DATA_W   = 8;
    localparam int unsigned RAM_AW   = 16;
    localparam int unsigned RAM_SIZE = 65536;
    localparam int unsigned PTR_W    = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W    = PTR_W + 1;

    localparam logic [ADDR_W-1:0] IO_DATA_ADDR = 17'h10000;
    localparam logic [ADDR_W-1:0] IO_STAT_ADDR = 17'h10004;

    logic [DATA_W-1:0] ram_q [RAM_SIZE];
    logic [DATA_W-1:0] d_out_q;
    logic [DATA_W-1:0] rd_data_c;
    logic [DATA_W-1:0] status_c;
    logic              is_ram_c;
    logic              is_io_data_c;
    logic              is_io_stat_c;
    logic              push_c;

    assign is_ram_c     = ~a_in[ADDR_W-1];
    assign is_io_data_c = (a_in == IO_DATA_ADDR);
    assign is_io_stat_c = (a_in == IO_STAT_ADDR);
    assign push_c       = ~wr & is_io_data_c;

    // RAM storage is never reset; writes coinciding with reset are dropped
    always_ff @(posedge clk) begin
        if (!rst && !wr && is_ram_c) begin
            ram_q[a_in[RAM_AW-1:0]] <= d_in;
        end
    end

    // Read mux uses pre-edge state, so status reflects the FIFO before this edge's push/pop
    always_comb begin
        rd_data_c = '0;
        if (is_ram_c) begin
            rd_data_c = ram_q[a_in[RAM_AW-1:0]];
        end else if (is_io_stat_c) begin
            rd_data_c = status_c;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            d_out_q <= '0;
        end else if (wr) begin
            d_out_q <= rd_data_c;
        end
    end

    assign d_out = d_out_q;

`ifdef RAM_RESPONDER_IO_FIFO_EN

    logic [DATA_W-1:0] fifo_q [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q;
    logic [PTR_W-1:0]  rd_ptr_q;
    logic [CNT_W-1:0]  count_q;
    logic              overflow_q;
    logic              empty_c;
    logic              full_c;
    logic              pop_c;
    logic              accept_c;

    assign empty_c  = (count_q == '0);
    assign full_c   = (count_q == CNT_W'(FIFO_DEPTH));
    assign pop_c    = ~empty_c & io_ready;
    // A pop frees the slot at the same edge, so a full FIFO still takes the push
    assign accept_c = push_c & (~full_c | pop_c);

    always_ff @(posedge clk) begin
        if (!rst && accept_c) begin
            fifo_q[wr_ptr_q] <= d_in;
        end
    end

    // Pointers wrap naturally because FIFO_DEPTH is a power of two
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (accept_c) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop_c) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            if (accept_c && !pop_c) begin
                count_q <= count_q + 1'b1;
            end else if (pop_c && !accept_c) begin
                count_q <= count_q - 1'b1;
            end
            if (push_c && !accept_c) begin
                overflow_q <= 1'b1;
            end
        end
    end

    assign status_c = {5'b0, overflow_q, full_c, empty_c};
    assign io_valid = ~empty_c;
    assign io_data  = empty_c ? 8'h00 : fifo_q[rd_ptr_q];

`else

    logic [DATA_W-1:0] io_data_q;
    logic              io_valid_q;
    logic              unused_c;

    // Without the FIFO an IO_DATA write is a single-cycle strobe; the byte stays on io_data
    always_ff @(posedge clk) begin
        if (rst) begin
            io_data_q  <= '0;
            io_valid_q <= 1'b0;
        end else begin
            io_valid_q <= push_c;
            if (push_c) begin
                io_data_q <= d_in;
            end
        end
    end

    assign status_c = 8'h01;
    assign io_valid = io_valid_q;
    assign io_data  = io_data_q;
    assign unused_c = ^{io_ready, CNT_W'(FIFO_DEPTH)};

`endif

endmodule

// File: tb/tb_ram_responder.sv
// Directed bench for ram_responder: behavioural RAM/FIFO model with a scoreboard of expected read bytes.
module tb_ram_responder;

    localparam int unsigned DEPTH = 8;
    localparam logic [16:0] IO_DATA = 17'h10000;
    localparam logic [16:0] IO_STAT = 17'h10004;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [16:0] a_in = '0;
    logic [7:0]  d_in = '0;
    logic        wr = 1'b1;
    logic [7:0]  d_out;
    logic [7:0]  io_data;
    logic        io_valid;
    logic        io_ready = 1'b0;

    int total = 0;
    int fails = 0;

    logic [7:0] sb_q [$];
    logic [7:0] ram_m [int];
    logic [7:0] fifo_m [$];
    logic       ovf_m = 1'b0;
    logic [7:0] last_dout = 8'h00;
    logic       io_v_m = 1'b0;
    logic [7:0] io_d_m = 8'h00;

    ram_responder #(.FIFO_DEPTH(DEPTH)) dut (
        .clk      (clk),
        .rst      (rst),
        .a_in     (a_in),
        .d_in     (d_in),
        .wr       (wr),
        .d_out    (d_out),
        .io_data  (io_data),
        .io_valid (io_valid),
        .io_ready (io_ready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] model_read(input logic [16:0] a);
        if (!a[16]) return ram_m.exists(int'(a[15:0])) ? ram_m[int'(a[15:0])] : 8'h00;
        if (a == IO_STAT) begin
`ifdef RAM_RESPONDER_IO_FIFO_EN
            return {5'b0, ovf_m, fifo_m.size() == DEPTH, fifo_m.size() == 0};
`else
            return 8'h01;
`endif
        end
        return 8'h00;
    endfunction

    // One bus cycle: predict, update the model, clock, then compare
    task automatic step(input logic w, input logic [16:0] a, input logic [7:0] d,
                        input logic rdy, input logic r);
        logic [7:0] exp;
        logic       push;
        wr = w; a_in = a; d_in = d; io_ready = rdy; rst = r;
        exp = r ? 8'h00 : (w ? model_read(a) : last_dout);
        sb_q.push_back(exp);
        last_dout = exp;
        push = !w && (a == IO_DATA);
        if (r) begin
            fifo_m.delete();
            ovf_m  = 1'b0;
            io_v_m = 1'b0;
            io_d_m = 8'h00;
        end else begin
            if (!w && !a[16]) ram_m[int'(a[15:0])] = d;
`ifdef RAM_RESPONDER_IO_FIFO_EN
            if (fifo_m.size() != 0 && rdy) void'(fifo_m.pop_front());
            if (push) begin
                if (fifo_m.size() < DEPTH) fifo_m.push_back(d);
                else ovf_m = 1'b1;
            end
`else
            io_v_m = push;
            if (push) io_d_m = d;
`endif
        end
        @(posedge clk);
        #1;
        chk("d_out", d_out, sb_q.pop_front());
`ifdef RAM_RESPONDER_IO_FIFO_EN
        chk("io_valid", {7'b0, io_valid}, {7'b0, fifo_m.size() != 0});
        chk("io_data", io_data, (fifo_m.size() != 0) ? fifo_m[0] : 8'h00);
`else
        chk("io_valid", {7'b0, io_valid}, {7'b0, io_v_m});
        chk("io_data", io_data, io_d_m);
`endif
    endtask

    initial begin
        // reset state
        step(1'b1, 17'h0, 8'h00, 1'b0, 1'b1);
        step(1'b1, 17'h0, 8'h00, 1'b0, 1'b1);
        chk("reset_d_out", d_out, 8'h00);
        chk("reset_io_valid", {7'b0, io_valid}, 8'h00);

        // write then read back; d_out holds during the write cycle
        step(1'b0, 17'h00010, 8'hA5, 1'b0, 1'b0);
        chk("write_hold_d_out", d_out, 8'h00);
        step(1'b1, 17'h00010, 8'h00, 1'b0, 1'b0);
        chk("readback_a5", d_out, 8'hA5);

        // preload and stream four reads
        step(1'b0, 17'h00100, 8'h13, 1'b0, 1'b0);
        step(1'b0, 17'h00101, 8'h00, 1'b0, 1'b0);
        step(1'b0, 17'h00102, 8'h05, 1'b0, 1'b0);
        step(1'b0, 17'h00103, 8'h93, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) step(1'b1, 17'h00100 + 17'(i), 8'h00, 1'b0, 1'b0);
        chk("stream_last_93", d_out, 8'h93);

        // unmapped space, IO_DATA read, writes to IO_STATUS / unmapped ignored
        step(1'b1, 17'h10008, 8'h00, 1'b0, 1'b0);
        chk("unmapped_read", d_out, 8'h00);
        step(1'b1, IO_DATA, 8'h00, 1'b0, 1'b0);
        step(1'b0, IO_STAT, 8'hFF, 1'b0, 1'b0);
        step(1'b0, 17'h10010, 8'h77, 1'b0, 1'b0);
        step(1'b1, 17'h00010, 8'h00, 1'b0, 1'b0);
        chk("no_alias_a5", d_out, 8'hA5);
        step(1'b1, IO_STAT, 8'h00, 1'b0, 1'b0);
        chk("status_idle", d_out, 8'h01);

`ifdef RAM_RESPONDER_IO_FIFO_EN
        // overflow: nine pushes into a depth-8 FIFO with no consumer
        for (int i = 1; i <= 9; i++) step(1'b0, IO_DATA, 8'(i), 1'b0, 1'b0);
        step(1'b1, IO_STAT, 8'h00, 1'b0, 1'b0);
        chk("status_full_ovf", d_out, 8'h06);
        for (int i = 1; i <= 8; i++) begin
            chk("drain_head", io_data, 8'(i));
            step(1'b1, 17'h00010, 8'h00, 1'b1, 1'b0);
        end
        chk("drained_empty", {7'b0, io_valid}, 8'h00);

        // full FIFO with simultaneous push and pop
        step(1'b1, 17'h0, 8'h00, 1'b0, 1'b1);
        for (int i = 0; i < 8; i++) step(1'b0, IO_DATA, 8'h20 + 8'(i), 1'b0, 1'b0);
        step(1'b0, IO_DATA, 8'h55, 1'b1, 1'b0);
        step(1'b1, IO_STAT, 8'h00, 1'b0, 1'b0);
        chk("status_full_no_ovf", d_out, 8'h02);
        for (int i = 0; i < 8; i++) begin
            if (i == 7) chk("last_is_55", io_data, 8'h55);
            step(1'b1, 17'h00010, 8'h00, 1'b1, 1'b0);
        end
`else
        // strobe mode: one-cycle io_valid, byte held on io_data
        step(1'b0, IO_DATA, 8'h41, 1'b0, 1'b0);
        chk("strobe_data", io_data, 8'h41);
        chk("strobe_valid", {7'b0, io_valid}, 8'h01);
        step(1'b1, 17'h00010, 8'h00, 1'b0, 1'b0);
        chk("strobe_valid_drop", {7'b0, io_valid}, 8'h00);
        chk("strobe_data_hold", io_data, 8'h41);
`endif

        // reset with queued bytes and a concurrent RAM write
        for (int i = 0; i < 3; i++) step(1'b0, IO_DATA, 8'hC0 + 8'(i), 1'b0, 1'b0);
        step(1'b0, 17'h00010, 8'hEE, 1'b0, 1'b1);
        chk("rst_io_valid", {7'b0, io_valid}, 8'h00);
        step(1'b1, IO_STAT, 8'h00, 1'b0, 1'b0);
        chk("rst_status", d_out, 8'h01);
        step(1'b1, 17'h00010, 8'h00, 1'b0, 1'b0);
        chk("ram_survives_rst", d_out, 8'hA5);

        $display("%0d/%0d checks passed", total - fails, total);
        $finish;
    end

endmodule
